aes_key_schedule: RTL and testbench

Byte-serial AES-128 key expansion stage that sits directly upstream of the byte-serial encryption datapath. It accepts the 128-bit cipher key one byte per handshake and expands it on the fly. It streams round keys 0 through 10, each as 16 bytes, to the encryptor's key byte input. Only the current round key is stored: 11×16 bytes are produced using one shared S-box lookup path.

---
 rtl/aes_key_schedule.sv | 178 +++++++++++++++++
 tb/tb_aes_key_schedule.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Byte-serial AES-128 key expansion: loads the cipher key bytewise and streams round keys 0..10.
// Optional replay of the stored cipher key: define AES_KEY_SCHEDULE_REPLAY_EN.
module aes_key_schedule (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] rk_byte,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic [3:0] rk_round,
    output logic       rk_last,
    output logic       done,
    input  logic       replay
);

    // Entry i lives at bits [(255-i)*8 +: 8], so the index is {~i, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {LOAD, EMIT, EXPAND} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [2:0]   e_q, e_d;
    logic [31:0]  temp_q, temp_d;
    logic [7:0]   sbox_in, sbox_q;
    logic         done_q, done_d;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [7:0]   rcon_next;

`ifdef AES_KEY_SCHEDULE_REPLAY_EN
    logic [127:0] copy_q, copy_d;
`else
    logic unused_replay;
    assign unused_replay = replay;
`endif

    assign w0n = key_q[127:96] ^ temp_q ^ {rcon_q, 24'h0};
    assign w1n = key_q[95:64] ^ w0n;
    assign w2n = key_q[63:32] ^ w1n;
    assign w3n = key_q[31:0] ^ w2n;
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        e_d     = e_q;
        temp_d  = temp_q;
        done_d  = 1'b0;
        sbox_in = '0;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
        copy_d  = copy_q;
`endif
        case (state_q)
            LOAD: begin
                if (key_valid) begin
                    key_d[{~cnt_q, 3'b000} +: 8] = key_in;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
                    copy_d[{~cnt_q, 3'b000} +: 8] = key_in;
`endif
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = EMIT;
                        round_d = '0;
                        rcon_d  = 8'h01;
                    end
                end
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
                // Replay wins over a coincident key byte and leaves the copy intact.
                if (replay) begin
                    key_d   = copy_q;
                    copy_d  = copy_q;
                    cnt_d   = '0;
                    round_d = '0;
                    rcon_d  = 8'h01;
                    state_d = EMIT;
                end
`endif
            end
            EMIT: begin
                if (rk_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (round_q == 4'd10) begin
                            state_d = LOAD;
                            done_d  = 1'b1;
                        end else begin
                            state_d = EXPAND;
                            e_d     = '0;
                        end
                    end
                end
            end
            EXPAND: begin
                e_d = e_q + 3'd1;
                // S-box output lags its input by one cycle, so temp byte e-1 lands at step e.
                case (e_q)
                    3'd0: sbox_in = key_q[23:16];
                    3'd1: begin
                        sbox_in       = key_q[15:8];
                        temp_d[31:24] = sbox_q;
                    end
                    3'd2: begin
                        sbox_in       = key_q[7:0];
                        temp_d[23:16] = sbox_q;
                    end
                    3'd3: begin
                        sbox_in      = key_q[31:24];
                        temp_d[15:8] = sbox_q;
                    end
                    3'd4: temp_d[7:0] = sbox_q;
                    default: begin
                        key_d   = {w0n, w1n, w2n, w3n};
                        round_d = round_q + 4'd1;
                        rcon_d  = rcon_next;
                        cnt_d   = '0;
                        state_d = EMIT;
                    end
                endcase
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LOAD;
            key_q   <= '0;
            cnt_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
            e_q     <= '0;
            temp_q  <= '0;
            sbox_q  <= '0;
            done_q  <= 1'b0;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
            copy_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            e_q     <= e_d;
            temp_q  <= temp_d;
            sbox_q  <= SBOX[{~sbox_in, 3'b000} +: 8];
            done_q  <= done_d;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
            copy_q  <= copy_d;
`endif
        end
    end

    assign key_ready = (state_q == LOAD);
    assign rk_valid  = (state_q == EMIT);
    assign rk_byte   = rk_valid ? key_q[{~cnt_q, 3'b000} +: 8] : '0;
    assign rk_round  = rk_valid ? round_q : '0;
    assign rk_last   = rk_valid && (cnt_q == 4'd15);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 key schedules, stalls, reset mid-stream, replay.
module tb_aes_key_schedule;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_in = '0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [7:0] rk_byte;
    logic       rk_valid;
    logic       rk_ready = 1'b0;
    logic [3:0] rk_round;
    logic       rk_last;
    logic       done;
    logic       replay = 1'b0;

    int nchecks = 0;
    int nerrors = 0;
    logic [7:0] got [176];

    localparam logic [127:0] KF = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KZ = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] rk;
    } vec_t;

    vec_t vec [13];

    always #5 clock = ~clock;

    aes_key_schedule dut (
        .clock    (clock),
        .reset    (reset),
        .key_in   (key_in),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .rk_byte  (rk_byte),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .done     (done),
        .replay   (replay)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " key_ready"}, 128'(key_ready), 128'(1));
        chk({tag, " rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, " rk_byte"}, 128'(rk_byte), 128'(0));
        chk({tag, " rk_round"}, 128'(rk_round), 128'(0));
        chk({tag, " rk_last"}, 128'(rk_last), 128'(0));
        chk({tag, " done"}, 128'(done), 128'(0));
    endtask

    task automatic load_key(input logic [127:0] k, input bit gaps, output int cycles);
        int i = 0;
        bit acc;
        cycles = 0;
        while (i < 16 && cycles < 1000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                key_valid = 1'b0;
                key_in    = 8'($urandom);
            end else begin
                key_valid = 1'b1;
                key_in    = k[127 - 8*i -: 8];
            end
            acc = key_valid && key_ready;
            @(posedge clock); #1;
            cycles++;
            if (acc) i++;
        end
        key_valid = 1'b0;
        chk("key bytes accepted", 128'(i), 128'(16));
    endtask

    // Collects 176 handshaken bytes; returns in the cycle where done should be high.
    task automatic run_stream(input bit stall, input bit poke, output int cycles);
        int nb = 0;
        int gap = 0;
        bit held = 1'b0;
        logic [7:0] hb = '0;
        logic [3:0] hr = '0;
        logic hl = 1'b0;
        cycles = 0;
        while (nb < 176 && cycles < 3000) begin
            rk_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (poke) begin
                key_valid = ($urandom_range(0, 1) == 1);
                key_in    = 8'($urandom);
            end
            if (rk_valid) begin
                if (held) begin
                    chk("stall hold byte", 128'(rk_byte), 128'(hb));
                    chk("stall hold round", 128'(rk_round), 128'(hr));
                    chk("stall hold last", 128'(rk_last), 128'(hl));
                end else if (nb % 16 == 0) begin
                    chk($sformatf("gap before round %0d", nb / 16), 128'(gap),
                        128'((nb == 0) ? 0 : 6));
                end
                gap = 0;
                if (rk_ready) begin
                    got[nb] = rk_byte;
                    chk("rk_round", 128'(rk_round), 128'(nb / 16));
                    chk("rk_last", 128'(rk_last), 128'((nb % 16) == 15));
                    nb++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hb   = rk_byte;
                    hr   = rk_round;
                    hl   = rk_last;
                end
            end else begin
                chk("done low mid-stream", 128'(done), 128'(0));
                gap++;
            end
            @(posedge clock); #1;
            cycles++;
        end
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        chk("stream complete", 128'(nb), 128'(176));
        chk("done pulse", 128'(done), 128'(1));
        chk("key_ready at done", 128'(key_ready), 128'(1));
    endtask

    task automatic compare_stream(input logic [127:0] k, input string tag);
        for (int v = 0; v < 13; v++) begin
            if (vec[v].key == k) begin
                logic [127:0] a;
                for (int b = 0; b < 16; b++) a[127 - 8*b -: 8] = got[vec[v].round*16 + b];
                chk($sformatf("%s round %0d", tag, vec[v].round), a, vec[v].rk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, sc, n, t;

        vec[0]  = '{KF, 0,  KF};
        vec[1]  = '{KF, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vec[2]  = '{KF, 2,  128'hf2c295f27a96b9435935807a7359f67f};
        vec[3]  = '{KF, 3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vec[4]  = '{KF, 4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vec[5]  = '{KF, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vec[6]  = '{KF, 6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vec[7]  = '{KF, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vec[8]  = '{KF, 8,  128'head27321b58dbad2312bf5607f8d292f};
        vec[9]  = '{KF, 9,  128'hac7766f319fadc2128d12941575c006e};
        vec[10] = '{KF, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vec[11] = '{KZ, 0,  KZ};
        vec[12] = '{KZ, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("power-on reset");
        reset = 1'b0;

        // Unstalled FIPS-197 stream and total latency
        load_key(KF, 1'b0, lc);
        run_stream(1'b0, 1'b0, sc);
        chk("total cycles", 128'(lc + sc), 128'(252));
        compare_stream(KF, "plain");

        // Replay requested in the done cycle
        replay = 1'b1;
        @(posedge clock); #1;
        replay = 1'b0;
`ifdef AES_KEY_SCHEDULE_REPLAY_EN
        chk("replay starts emit", 128'(rk_valid), 128'(1));
        run_stream(1'b0, 1'b0, sc);
        compare_stream(KF, "replay");
        @(posedge clock); #1;
`else
        chk("replay ignored valid", 128'(rk_valid), 128'(0));
        repeat (3) @(posedge clock);
        #1;
        chk("replay ignored valid later", 128'(rk_valid), 128'(0));
        chk("replay ignored key_ready", 128'(key_ready), 128'(1));
`endif
        chk("done falls", 128'(done), 128'(0));

        // Random stalls and key_valid gaps
        load_key(KF, 1'b1, lc);
        run_stream(1'b1, 1'b0, sc);
        compare_stream(KF, "stalled");
        @(posedge clock); #1;

        // Garbage key_valid pulses while emitting
        load_key(KF, 1'b0, lc);
        run_stream(1'b0, 1'b1, sc);
        compare_stream(KF, "poked");
        @(posedge clock); #1;

        // Reset at round 4 byte 7, then a different key
        load_key(KF, 1'b0, lc);
        rk_ready = 1'b1;
        n = 0;
        t = 0;
        while (n < 71 && t < 500) begin
            if (rk_valid) n++;
            @(posedge clock); #1;
            t++;
        end
        chk("pre-reset rk_round", 128'(rk_round), 128'(4));
        chk("pre-reset rk_byte", 128'(rk_byte), 128'(8'h7f));
        reset = 1'b1;
        @(posedge clock); #1;
        chk_reset_outputs("mid-emit reset");
        reset    = 1'b0;
        rk_ready = 1'b0;
        load_key(KZ, 1'b0, lc);
        run_stream(1'b0, 1'b0, sc);
        compare_stream(KZ, "after reset");
        @(posedge clock); #1;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
